mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: word-addressed memory controller with read, write and increment
// (read-modify-write). Define MEM_PARITY_EN to store and check odd parity per word.
module mem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned MAX_ADDRESS = 10239
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  par_force,
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  oor,
  output logic                  carry,
  output logic                  perr
);

  localparam int unsigned DEPTH = MAX_ADDRESS + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH+31:0] MAX_EXT = (ADDR_WIDTH + 32)'(MAX_ADDRESS);

`ifdef MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MODIFY = 2'd2;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] temp_q, temp_d;
  logic                  tperr_q, tperr_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oor_q, oor_d;
  logic                  carry_q, carry_d;
  logic                  perr_q, perr_d;

  logic [WORD_W-1:0]     mem_q [0:MAX_ADDRESS];
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     wr_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] inc_sum;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  rd_perr;
  logic                  mem_we;

  // Range check uses the full captured address so high bits cannot alias into the array.
  assign in_range = ({32'd0, addr_q} <= MAX_EXT);
  assign idx      = addr_q[IDX_W-1:0];
  assign rd_word  = mem_q[idx];
  assign rd_data  = rd_word[DATA_WIDTH-1:0];
  assign inc_sum  = temp_q + DATA_WIDTH'(1);

`ifdef MEM_PARITY_EN
  logic pf_q, pf_d;
  logic wr_force;
  assign rd_perr = ~(^rd_word);
  assign wr_word = {(~(^wr_data)) ^ wr_force, wr_data};
`else
  logic unused_par_force;
  assign unused_par_force = par_force;
  assign rd_perr = 1'b0;
  assign wr_word = wr_data;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    temp_d  = temp_q;
    tperr_d = tperr_q;
    ack_d   = 1'b0;
    dout_d  = dout_q;
    oor_d   = 1'b0;
    carry_d = 1'b0;
    perr_d  = 1'b0;
    mem_we  = 1'b0;
    wr_data = '0;
`ifdef MEM_PARITY_EN
    pf_d     = pf_q;
    wr_force = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          din_d   = din;
`ifdef MEM_PARITY_EN
          pf_d    = par_force;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (op_q == OP_INC) begin
          temp_d  = rd_data;
          tperr_d = in_range & rd_perr;
          state_d = S_MODIFY;
        end else begin
          // Reserved op 11 falls through to the read path.
          if (op_q == OP_WRITE) begin
            mem_we  = in_range;
            wr_data = din_q;
`ifdef MEM_PARITY_EN
            wr_force = pf_q;
`endif
            dout_d  = in_range ? din_q : '0;
          end else begin
            dout_d  = in_range ? rd_data : '0;
            perr_d  = in_range & rd_perr;
          end
          oor_d   = ~in_range;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MODIFY: begin
        mem_we  = in_range;
        wr_data = inc_sum;
        dout_d  = in_range ? inc_sum : '0;
        carry_d = in_range & (&temp_q);
        perr_d  = tperr_q;
        oor_d   = ~in_range;
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      temp_q  <= '0;
      tperr_q <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      oor_q   <= 1'b0;
      carry_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      temp_q  <= temp_d;
      tperr_q <= tperr_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      oor_q   <= oor_d;
      carry_q <= carry_d;
      perr_q  <= perr_d;
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pf_q <= 1'b0;
    else       pf_q <= pf_d;
  end
`endif

  // Array has no reset; reset level also blocks a write racing an abort.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[idx] <= wr_word;
  end

  assign busy  = (state_q != S_IDLE);
  assign ack   = ack_q;
  assign dout  = dout_q;
  assign oor   = oor_q;
  assign carry = carry_q;
  assign perr  = perr_q;

endmodule
